// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits (LSB or MSB first),
// optional parity bit (enabled by defining UART_TX_PARITY_EN), STOP_BITS stop bits.
module uart_tx_cfg #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int LSB_FIRST  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BAUD_LOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_cfg: illegal parameter set");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic [CW-1:0]          baud_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
`ifdef UART_TX_PARITY_EN
    logic                   parity_bit;
`endif

    logic                 bit_end;
    logic                 first_bit;
    logic                 next_bit;
    logic [DATA_BITS-1:0] shifted;

    assign bit_end  = (baud_cnt == '0);
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // next_bit is the bit that becomes current once the shift register advances
    assign first_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_BITS-1];
    assign next_bit  = (LSB_FIRST != 0) ? shreg[1] : shreg[DATA_BITS-2];
    assign shifted   = (LSB_FIRST != 0) ? {1'b0, shreg[DATA_BITS-1:1]}
                                        : {shreg[DATA_BITS-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx         <= 1'b1;
            done       <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (in_valid) begin
                        state    <= START;
                        tx       <= 1'b0;
                        baud_cnt <= BAUD_LOAD;
                        bit_cnt  <= '0;
                        shreg    <= in_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= (^in_data) ^ (PARITY_ODD != 0);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        tx       <= first_bit;
                        baud_cnt <= BAUD_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= parity_bit;
`else
                            state   <= STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shifted;
                            tx      <= next_bit;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        baud_cnt <= BAUD_LOAD;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 1'b1;
                            baud_cnt <= BAUD_LOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: two instances (8-bit LSB-first 1 stop, 7-bit MSB-first
// 2 stop odd parity); a line monitor decodes each frame and compares it to queued expectations.
module tb_uart_tx_cfg;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       val_a = 1'b0, val_b = 1'b0;
    logic [7:0] data_a = '0;
    logic [6:0] data_b = '0;
    logic       rdy_a, rdy_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(8), .STOP_BITS(1), .LSB_FIRST(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(val_a), .in_data(data_a),
        .in_ready(rdy_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_tx_cfg #(.CLK_DIV(DIV), .DATA_BITS(7), .STOP_BITS(2), .LSB_FIRST(0), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(val_b), .in_data(data_b),
        .in_ready(rdy_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nbits(input int d);
        return (d == 0) ? 8 : 7;
    endfunction

    function automatic int frame_len(input int d);
        int p = 0;
`ifdef UART_TX_PARITY_EN
        p = 1;
`endif
        return 1 + nbits(d) + p + ((d == 0) ? 1 : 2);
    endfunction

    // Expected tx level for each bit period of the frame, bit 0 = start bit
    function automatic logic [15:0] frame_of(input int d, input logic [8:0] w);
        logic [15:0] v   = '0;
        int          nb  = nbits(d);
        int          pos = 1;
        logic        par = 1'b0;
        for (int i = 0; i < nb; i++) begin
            v[pos] = (d == 0) ? w[i] : w[nb-1-i];
            par    = par ^ w[i];
            pos++;
        end
`ifdef UART_TX_PARITY_EN
        v[pos] = (d == 0) ? par : ~par;
        pos++;
`endif
        for (int i = 0; i < ((d == 0) ? 1 : 2); i++) begin
            v[pos] = 1'b1;
            pos++;
        end
        return v;
    endfunction

    function automatic logic txv(input int d);
        return (d == 0) ? tx_a : tx_b;
    endfunction

    function automatic logic rdyv(input int d);
        return (d == 0) ? rdy_a : rdy_b;
    endfunction

    function automatic logic donev(input int d);
        return (d == 0) ? done_a : done_b;
    endfunction

    // Line monitor
    bit          act[2]      = '{0, 0};
    bit          dlow[2]     = '{0, 0};
    int          off[2]      = '{0, 0};
    int          gap[2]      = '{0, 0};
    int          last_end[2] = '{0, 0};
    logic [15:0] rx[2];
    int          cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    act[d]  = 0;
                    dlow[d] = 0;
                end else begin
                    if (dlow[d]) begin
                        check($sformatf("done_one_cycle[%0d]", d), donev(d), 1'b0);
                        dlow[d] = 0;
                    end
                    if (!act[d]) begin
                        if (txv(d) == 1'b0) begin
                            act[d] = 1;
                            off[d] = 0;
                            rx[d]  = '0;
                            gap[d] = cyc - last_end[d];
                        end
                    end else begin
                        off[d]++;
                        if (off[d] % DIV == 1 && off[d] / DIV < frame_len(d))
                            rx[d][off[d] / DIV] = txv(d);
                        if (off[d] == frame_len(d) * DIV - 1) begin
                            check($sformatf("ready_low_last[%0d]", d), rdyv(d), 1'b0);
                            check($sformatf("done_early[%0d]", d), donev(d), 1'b0);
                        end
                        if (off[d] == frame_len(d) * DIV) begin
                            logic [15:0] exp;
                            check($sformatf("done_pulse[%0d]", d), donev(d), 1'b1);
                            check($sformatf("ready_end[%0d]", d), rdyv(d), 1'b1);
                            if ((d == 0 ? q_a.size() : q_b.size()) == 0) begin
                                check($sformatf("unexpected_frame[%0d]", d), {16'd0, rx[d]}, 32'hFFFF_FFFF);
                            end else begin
                                exp = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                                check($sformatf("frame_bits[%0d]", d), {16'd0, rx[d]}, {16'd0, exp});
                            end
                            act[d]      = 0;
                            dlow[d]     = 1;
                            last_end[d] = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int d, input logic [8:0] w, input bit push, input bit keep);
        int n = 0;
        @(negedge clk);
        if (d == 0) begin data_a = w[7:0]; val_a = 1'b1; end
        else        begin data_b = w[6:0]; val_b = 1'b1; end
        while (!rdyv(d) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rdyv(d)) check("accept_timeout", 0, 1);
        else if (push) begin
            if (d == 0) q_a.push_back(frame_of(0, w));
            else        q_b.push_back(frame_of(1, w));
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (d == 0) val_a = 1'b0;
            else        val_b = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || act[0] || act[1]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < 2000), 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx_a, 1'b1);
        check("rst_ready", rdy_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame and first-edge latency
        send(0, 9'h0A5, 1, 0);
        check("start_latency", tx_a, 1'b0);
        check("busy_after_accept", busy_a, 1'b1);
        drain();

        // Back-to-back with in_valid held high
        send(0, 9'h000, 1, 1);
        send(0, 9'h0FF, 1, 0);
        drain();
        check("b2b_gap", gap[0], 1);

        // 7-bit MSB-first, two stop bits
        send(1, 9'h001, 1, 0);
        drain();

        // Parity sense on both instances (plain frames when parity is compiled out)
        send(0, 9'h007, 1, 0);
        send(1, 9'h007, 1, 0);
        drain();

        // Asynchronous reset during data bit 3
        send(0, 9'h055, 0, 0);
        repeat (17) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx_a, 1'b1);
        check("async_rst_ready", rdy_a, 1'b1);
        check("async_rst_busy", busy_a, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, 9'h03C, 1, 0);
        drain();

        // Input churn during a frame must not leak into the line
        send(0, 9'h081, 1, 0);
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            data_a = 8'($urandom);
        end
        drain();

        // A few random words on both instances
        for (int i = 0; i < 4; i++) begin
            send(0, 9'($urandom_range(0, 255)), 1, 0);
            send(1, 9'($urandom_range(0, 127)), 1, 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmit block. Serialises one word per frame at a programmable baud divider. Frame format is configurable: data width, stop bit count and bit order. Takes words over a valid/ready handshake from upstream logic (NN result streamer, debug console) and drives the board TX pin directly.

Parameters:
- CLK_DIV, 868, clk cycles per bit (100 MHz / 115200); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- LSB_FIRST, 1, 1 = bit 0 sent first (standard UART); 0 = MSB sent first.
- PARITY_ODD, 0, parity sense: 0 = even, 1 = odd. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream has a word on in_data.
- in_data  in  DATA_BITS  word to transmit.
- in_ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  frame in progress; equals !in_ready.
- done  out  1  one-cycle pulse at end of last stop bit.

Behaviour:
- Reset (async, rst_n low): state IDLE, tx=1, in_ready=1, busy=0, done=0, all counters and shift register 0. Applies immediately mid-frame; line returns high with no partial stop bit.
- tx, done and state are registered outputs, no combinational path from inputs. in_ready is decoded from state only (state==IDLE).
- Handshake: word accepted on the rising edge where in_valid && in_ready. in_data is latched into the shift register on that edge. in_data and in_valid changes after acceptance are ignored until the next IDLE.
- FSM states:
  - IDLE -> START on accept.
  - START -> DATA after CLK_DIV cycles.
  - DATA -> PARITY (if enabled) or STOP after DATA_BITS bit periods.
  - PARITY -> STOP after 1 bit period.
  - STOP -> IDLE after STOP_BITS bit periods.
- Baud timing: counter loads CLK_DIV-1 on each bit start and counts down. The bit ends when the counter reaches 0, so every bit lasts exactly CLK_DIV cycles. Counter width is $clog2(CLK_DIV).
- Bit counter width is $clog2(DATA_BITS+1). Shift register shifts right when LSB_FIRST=1, left otherwise.
- Latency: tx falls to 0 (start bit) on the edge after acceptance.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) * CLK_DIV cycles, where P = 1 with parity enabled, else 0.
- done is asserted in the first IDLE cycle after the frame, for exactly one cycle.
- Back-to-back: if in_valid is held high, the next word is accepted in that same IDLE cycle. Minimum inter-frame gap is therefore STOP_BITS bit periods plus 1 clk of idle-high.
- tx holds 1 throughout IDLE and STOP.
- No FIFO; upstream must stall on in_ready low.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state is inserted between DATA and STOP. Parity bit = XOR of the latched word, inverted if PARITY_ODD=1. Parity is computed at accept time from the latched word.
- Undefined: no PARITY state and no parity logic; PARITY_ODD is unused. Frames are DATA_BITS-N-STOP_BITS.

Test Plan:
1. CLK_DIV=4, DATA_BITS=8, LSB_FIRST=1, no parity; send 0xA5.
   -> tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 clks.
   -> in_ready low for 40 clks; done pulses on clk 41 after accept.
2. Same config, in_valid held high with 0x00 then 0xFF.
   -> second start bit begins exactly 1 idle clk after the first frame's stop bit.
   -> no word dropped or repeated; two done pulses.
3. STOP_BITS=2, LSB_FIRST=0, DATA_BITS=7; send 0x01.
   -> tx = 0, 0,0,0,0,0,0,1, 1,1, frame 40 clks at CLK_DIV=4.
4. UART_TX_PARITY_EN, PARITY_ODD=0; send 0x07.
   -> parity bit 1, frame 11 bits.
   -> repeat with PARITY_ODD=1: parity bit 0.
5. Assert rst_n low mid-DATA bit 3 of 0x55.
   -> tx=1 and in_ready=1 asynchronously.
   -> after release, a new word 0x3C transmits as a clean full frame.
6. Change in_data every clk during a frame of 0x81.
   -> transmitted bits equal 0x81 only.
